// File: rtl/disto_mode_sched.sv
// Schedules one shared weighted-distortion engine across the enabled candidate modes
// of a macroblock, biases each returned distortion and keeps the cheapest mode.
module disto_mode_sched #(
    parameter int NUM_MODES = 4,
    parameter int IDX_W     = 2,
    parameter int TIMEOUT   = 63
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_MODES-1:0]    mode_mask,
    input  logic [32*NUM_MODES-1:0] bias,
    output logic                    eng_start,
    output logic [IDX_W-1:0]        eng_sel,
    input  logic [31:0]             eng_sum,
    input  logic                    eng_done,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        best_idx,
    output logic [31:0]             best_score,
    output logic                    best_valid,
    output logic                    timeout_err
);

    localparam int               CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_MODES - 1);
    localparam logic [31:0]      SCORE_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0]      SCORE_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ISSUE,
        S_WAIT,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MODES-1:0] mask_q, mask_d;
    logic [31:0]        bias_q [NUM_MODES];
    logic [31:0]        bias_d [NUM_MODES];
    logic [31:0]        bias_in [NUM_MODES];
    logic               eng_start_q, eng_start_d;
    logic [IDX_W-1:0]   eng_sel_q, eng_sel_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [31:0]        best_score_q, best_score_d;
    logic               best_valid_q, best_valid_d;
    logic               timeout_err_q, timeout_err_d;

    logic [31:0]        cur_bias;
    logic signed [32:0] raw_sum;
    logic [31:0]        score;
    logic               better;
    logic               last_mode;

    for (genvar g = 0; g < NUM_MODES; g++) begin : g_bias
        assign bias_in[g] = bias[32*g +: 32];
    end

    // 33-bit add cannot overflow; clamp back into the signed 32-bit range.
    always_comb begin
        cur_bias = bias_q[ptr_q];
        raw_sum  = $signed({eng_sum[31], eng_sum}) + $signed({cur_bias[31], cur_bias});
        if (raw_sum[32] != raw_sum[31]) begin
            score = raw_sum[32] ? SCORE_MIN : SCORE_MAX;
        end else begin
            score = raw_sum[31:0];
        end
        better    = !best_valid_q || ($signed(score) < $signed(best_score_q));
        last_mode = (ptr_q == LAST_IDX);
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        mask_d        = mask_q;
        bias_d        = bias_q;
        eng_start_d   = 1'b0;
        eng_sel_d     = eng_sel_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        best_idx_d    = best_idx_q;
        best_score_d  = best_score_q;
        best_valid_d  = best_valid_q;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped, not queued.
                if (start && !done_q) begin
                    mask_d        = mode_mask;
                    bias_d        = bias_in;
                    best_valid_d  = 1'b0;
                    timeout_err_d = 1'b0;
                    best_score_d  = SCORE_MAX;
                    best_idx_d    = '0;
                    ptr_d         = '0;
                    busy_d        = 1'b1;
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q[ptr_q]) begin
                    eng_start_d = 1'b1;
                    eng_sel_d   = ptr_q;
                    state_d     = S_ISSUE;
                end else if (last_mode) begin
                    state_d = S_FIN;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done || (cnt_q == CNT_W'(TIMEOUT))) begin
                    if (eng_done) begin
                        if (better) begin
                            best_score_d = score;
                            best_idx_d   = ptr_q;
                        end
                        best_valid_d = 1'b1;
                    end else begin
                        timeout_err_d = 1'b1;
                    end
                    if (last_mode) begin
                        state_d = S_FIN;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_SCAN;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            mask_q        <= '0;
            for (int unsigned m = 0; m < NUM_MODES; m++) begin
                bias_q[m] <= '0;
            end
            eng_start_q   <= 1'b0;
            eng_sel_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            best_idx_q    <= '0;
            best_score_q  <= SCORE_MAX;
            best_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            mask_q        <= mask_d;
            bias_q        <= bias_d;
            eng_start_q   <= eng_start_d;
            eng_sel_q     <= eng_sel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            best_idx_q    <= best_idx_d;
            best_score_q  <= best_score_d;
            best_valid_q  <= best_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign eng_start   = eng_start_q;
    assign eng_sel     = eng_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign best_idx    = best_idx_q;
    assign best_score  = best_score_q;
    assign best_valid  = best_valid_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_disto_mode_sched.sv
// Randomised bench for disto_mode_sched: an engine model answers issues, and a
// schedule/result model computed per run is compared against the DUT every cycle.
module tb_disto_mode_sched;

    localparam int NM = 4;
    localparam int IW = 2;
    localparam int TO = 63;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [NM-1:0]   mode_mask = '0;
    logic [32*NM-1:0] bias = '0;
    logic [31:0]     eng_sum = '0;
    logic            eng_done = 1'b0;
    logic            eng_start;
    logic [IW-1:0]   eng_sel;
    logic            busy;
    logic            done;
    logic [IW-1:0]   best_idx;
    logic [31:0]     best_score;
    logic            best_valid;
    logic            timeout_err;

    disto_mode_sched #(.NUM_MODES(NM), .IDX_W(IW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_mask(mode_mask), .bias(bias),
        .eng_start(eng_start), .eng_sel(eng_sel), .eng_sum(eng_sum), .eng_done(eng_done),
        .busy(busy), .done(done), .best_idx(best_idx), .best_score(best_score),
        .best_valid(best_valid), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-run stimulus tables (w == 0 means the engine never answers that mode).
    logic [NM-1:0] r_mask = '0;
    int r_bias [NM];
    int r_sum  [NM];
    int r_w    [NM];

    // Expected schedule and results for the current run.
    bit          mon_en = 0;
    int          run_c = -10;
    int          run_D = -10;
    int          iss [NM];
    int          wle [NM];
    logic [IW-1:0] e_idx = '0;
    logic [31:0] e_score = 32'h7FFF_FFFF;
    logic        e_valid = 1'b0;
    logic        e_terr = 1'b0;

    int es_q[$];
    int sel_q[$];
    int last_done = -1;

    task automatic wait_cycle();
        @(posedge clk);
        #2;
    endtask

    // Engine: answers w cycles after seeing eng_start; stray done pulses when idle.
    initial begin : engine
        int pend;
        int cnt;
        int sel;
        bit hold;
        pend = 0; cnt = 0; sel = 0; hold = 0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (!rst_n) begin
                pend = 0;
                hold = 0;
            end else begin
                if (done) hold = 0;
                if (pend != 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        eng_done = 1'b1;
                        eng_sum  = r_sum[sel];
                        pend     = 0;
                    end
                end
                if (eng_start) begin
                    sel  = int'(eng_sel);
                    hold = 0;
                    if (r_w[sel] == 0) hold = 1;
                    else begin
                        pend = 1;
                        cnt  = r_w[sel];
                    end
                end else if (pend == 0 && !hold && !eng_done && $urandom_range(0, 7) == 0) begin
                    eng_done = 1'b1;
                    eng_sum  = $urandom;
                end
            end
        end
    end

    // Per-cycle comparison against the planned schedule and results.
    initial begin : compare
        forever begin
            bit exp_es;
            @(negedge clk);
            if (mon_en) begin
                exp_es = 0;
                for (int m = 0; m < NM; m++) if (iss[m] == cyc) exp_es = 1;
                chk("busy", busy, (cyc > run_c) && (cyc < run_D));
                chk("done", done, cyc == run_D);
                chk("eng_start", eng_start, exp_es);
                for (int m = 0; m < NM; m++) begin
                    if (iss[m] >= 0 && cyc >= iss[m] && cyc <= iss[m] + wle[m])
                        chk("eng_sel", eng_sel, m);
                end
                if (cyc >= run_D) begin
                    chk("best_idx", best_idx, e_idx);
                    chk("best_score", best_score, e_score);
                    chk("best_valid", best_valid, e_valid);
                    chk("timeout_err", timeout_err, e_terr);
                end
                if (eng_start) begin
                    es_q.push_back(cyc);
                    sel_q.push_back(int'(eng_sel));
                end
                if (done) last_done = cyc;
            end
        end
    end

    // Plan the run from the tables, then pulse start in this cycle.
    task automatic plan_and_start();
        int t;
        longint sc;
        longint bs;
        bit bv;
        es_q.delete();
        sel_q.delete();
        last_done = -1;
        run_c = cyc;
        t = cyc + 1;
        for (int m = 0; m < NM; m++) begin
            if (r_mask[m]) begin
                iss[m] = t + 1;
                wle[m] = (r_w[m] == 0) ? TO + 1 : r_w[m];
                t += 2 + wle[m];
            end else begin
                iss[m] = -1;
                t += 1;
            end
        end
        run_D = t + 1;
        bv = 0; bs = 64'sh7FFF_FFFF; e_idx = '0; e_terr = 1'b0;
        for (int m = 0; m < NM; m++) begin
            if (r_mask[m]) begin
                if (r_w[m] == 0) e_terr = 1'b1;
                else begin
                    sc = longint'(r_sum[m]) + longint'(r_bias[m]);
                    if (sc > 64'sh7FFF_FFFF) sc = 64'sh7FFF_FFFF;
                    if (sc < -64'sh8000_0000) sc = -64'sh8000_0000;
                    if (!bv || sc < bs) begin
                        bs = sc;
                        e_idx = IW'(m);
                    end
                    bv = 1;
                end
            end
        end
        e_valid = bv;
        e_score = bs[31:0];
        start = 1'b1;
        mode_mask = r_mask;
        bias = {r_bias[3], r_bias[2], r_bias[1], r_bias[0]};
    endtask

    task automatic run_one(input bit extra);
        plan_and_start();
        do begin
            wait_cycle();
            start = 1'b0;
            if (extra && cyc <= run_D && (cyc == run_D || $urandom_range(0, 5) == 0)) begin
                start = 1'b1;
                mode_mask = NM'($urandom);
                bias = {$urandom, $urandom, $urandom, $urandom};
            end
        end while (cyc <= run_D);
        start = 1'b0;
    endtask

    task automatic set_run(input logic [NM-1:0] mk, input int s0, s1, s2, s3,
                           input int b0, b1, b2, b3, input int w0, w1, w2, w3);
        r_mask = mk;
        r_sum[0] = s0; r_sum[1] = s1; r_sum[2] = s2; r_sum[3] = s3;
        r_bias[0] = b0; r_bias[1] = b1; r_bias[2] = b2; r_bias[3] = b3;
        r_w[0] = w0; r_w[1] = w1; r_w[2] = w2; r_w[3] = w3;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_eng_start"}, eng_start, 0);
        chk({tag, "_eng_sel"}, eng_sel, 0);
        chk({tag, "_best_idx"}, best_idx, 0);
        chk({tag, "_best_score"}, best_score, 64'h7FFF_FFFF);
        chk({tag, "_best_valid"}, best_valid, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic idle_expect();
        run_c = -10; run_D = -10;
        for (int m = 0; m < NM; m++) iss[m] = -1;
        e_idx = '0; e_score = 32'h7FFF_FFFF; e_valid = 1'b0; e_terr = 1'b0;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1);
    end

    initial begin : main
        int c0;
        for (int m = 0; m < NM; m++) begin
            iss[m] = -1; wle[m] = 0; r_w[m] = 1; r_sum[m] = 0; r_bias[m] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        wait_cycle();
        rst_n = 1'b1;
        idle_expect();
        mon_en = 1;
        repeat (3) wait_cycle();

        // 1: all modes, tie at 300 keeps index 1
        set_run(4'b1111, 500, 300, 700, 300, 0, 0, 0, 0, 17, 17, 17, 17);
        run_one(0);
        chk("t1_idx", best_idx, 1);
        chk("t1_score", best_score, 300);
        chk("t1_valid", best_valid, 1);
        chk("t1_starts", es_q.size(), 4);
        for (int k = 0; k < 4; k++) chk("t1_sel_order", (k < sel_q.size()) ? sel_q[k] : -1, k);
        chk("t1_gap", (es_q.size() >= 2) ? es_q[1] - es_q[0] : -1, 19);

        // 2: sparse mask, bias pushes mode 2 above mode 0
        set_run(4'b0101, 900, 5, 100, 5, 0, 0, 1000, 0, 17, 17, 17, 17);
        run_one(1);
        chk("t2_idx", best_idx, 0);
        chk("t2_score", best_score, 900);
        chk("t2_starts", es_q.size(), 2);

        // 3: empty mask
        set_run(4'b0000, 1, 2, 3, 4, 0, 0, 0, 0, 5, 5, 5, 5);
        c0 = cyc;
        run_one(0);
        chk("t3_done_lat", last_done - c0, 6);
        chk("t3_valid", best_valid, 0);
        chk("t3_score", best_score, 64'h7FFF_FFFF);
        chk("t3_starts", es_q.size(), 0);

        // 4: mode 0 never answers
        set_run(4'b0011, 40, 50, 0, 0, 0, 0, 0, 0, 0, 10, 1, 1);
        run_one(0);
        chk("t4_gap", (es_q.size() >= 2) ? es_q[1] - es_q[0] : -1, 66);
        chk("t4_terr", timeout_err, 1);
        chk("t4_idx", best_idx, 1);

        // 5: positive saturation, then a negative score wins
        set_run(4'b0001, 32'h7FFF_FFF0, 0, 0, 0, 100, 0, 0, 0, 8, 8, 8, 8);
        run_one(0);
        chk("t5a_score", best_score, 64'h7FFF_FFFF);
        chk("t5a_valid", best_valid, 1);
        set_run(4'b0011, 32'h7FFF_FFF0, -5, 0, 0, 100, -10, 0, 0, 8, 12, 8, 8);
        run_one(1);
        chk("t5b_idx", best_idx, 1);
        chk("t5b_score", best_score, 64'hFFFF_FFF1);

        // 6: reset in the middle of WAIT, then a clean run
        set_run(4'b1111, 10, 20, 30, 40, 0, 0, 0, 0, 17, 17, 17, 17);
        plan_and_start();
        wait_cycle();
        start = 1'b0;
        while (cyc < iss[1] + 5) wait_cycle();
        rst_n = 1'b0;
        mon_en = 0;
        @(negedge clk);
        chk_reset_vals("midrst");
        wait_cycle();
        wait_cycle();
        rst_n = 1'b1;
        idle_expect();
        mon_en = 1;
        repeat (6) wait_cycle();
        set_run(4'b1010, 0, 77, 0, 33, 0, 0, 0, 50, 3, 4, 5, 6);
        run_one(0);
        chk("t6_idx", best_idx, 1);
        chk("t6_score", best_score, 77);

        // Randomised runs
        for (int r = 0; r < 40; r++) begin
            r_mask = NM'($urandom_range(0, 15));
            for (int m = 0; m < NM; m++) begin
                case ($urandom_range(0, 5))
                    0: r_bias[m] = int'(32'h7FFF_FF00) + int'($urandom_range(0, 255));
                    1: r_bias[m] = int'(32'h8000_0000) + int'($urandom_range(0, 255));
                    default: r_bias[m] = int'($urandom_range(0, 200)) - 100;
                endcase
                case ($urandom_range(0, 5))
                    0: r_sum[m] = int'(32'h7FFF_FFF0) + int'($urandom_range(0, 15));
                    1: r_sum[m] = int'(32'h8000_0000) + int'($urandom_range(0, 15));
                    default: r_sum[m] = int'($urandom_range(0, 4)) * 50;
                endcase
                if ($urandom_range(0, 9) == 0) r_w[m] = 0;
                else if ($urandom_range(0, 9) == 0) r_w[m] = 63;
                else r_w[m] = int'($urandom_range(1, 20));
            end
            run_one(bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) wait_cycle();
        end

        mon_en = 0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
